dram_feature_rd_burst: RTL and testbench

- Downstream of the feature read-address generator.
- Consumes its one-cycle line-load request (start address in 16-byte beat units plus line length), splits the line into AXI4 INCR read bursts that never cross a 4 KB boundary, and issues them on the AR channel.
- Counts returned R beats and forwards them to the feature line buffer.
- Pulses a line-done strobe after the final beat of the line.

---
 rtl/dram_feature_rd_burst_if.sv | 28 ++
 rtl/dram_feature_rd_burst.sv | 196 +++++++++++++++++++
 tb/tb_dram_feature_rd_burst.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_feature_rd_burst_if.sv
// AXI4 read-address and read-data channel bundle for the feature-line reader.
// master: the burst issuer (drives AR and rready); slave: the memory side.
interface dram_feature_rd_burst_if #(
  parameter int LITEWIDTH = 32,
  parameter int AXIWIDTH  = 128
);
  logic [LITEWIDTH-1:0] araddr;
  logic [7:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;
  logic [AXIWIDTH-1:0]  rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dram_feature_rd_burst.sv
// Feature-line DRAM reader: splits one line-load request into AXI4 INCR read
// bursts (never crossing a 4 KB boundary), counts the returned beats, forwards
// them to the line buffer and pulses O_line_done when the line is complete.
// One further request can wait in a pending slot; a request that finds the
// slot full is dropped and flagged on the sticky O_overflow.
// Optional: define DRAM_RD_RRESP_CHECK_EN to flag non-OKAY read responses on
// the sticky O_rresp_err; otherwise O_rresp_err is tied low.
module dram_feature_rd_burst #(
  parameter int LITEWIDTH = 32,
  parameter int AXIWIDTH  = 128,
  parameter int LENWIDTH  = 19,
  parameter int MAX_BURST = 16
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_rd_flag,
  input  logic [LITEWIDTH-1:0]    I_rd_addr,
  input  logic [LENWIDTH-1:0]     I_beat_num,
  output logic                    O_busy,
  output logic                    O_line_done,
  output logic                    O_overflow,
  dram_feature_rd_burst_if.master axi,
  input  logic                    I_data_ready,
  output logic [AXIWIDTH-1:0]     O_data,
  output logic                    O_data_valid,
  output logic                    O_rresp_err
);

  // Beat counters are one bit wider than the line length.
  localparam int CW = LENWIDTH + 1;

  typedef enum logic [1:0] {IDLE, CALC, AREQ, DRAIN} state_t;

  state_t               state;
  logic [LITEWIDTH-1:0] addr_q;     // next burst start, beat units
  logic [CW-1:0]        remain_q;   // beats of the line not yet requested
  logic [CW-1:0]        blen_q;     // length of the burst on the AR channel
  logic [CW-1:0]        expect_q;   // requested beats not yet returned

  logic                 pend_valid;
  logic [LITEWIDTH-1:0] pend_addr;
  logic [LENWIDTH-1:0]  pend_len;

  logic                 ar_hs;
  logic                 beat;
  logic                 drain_done;
  logic [8:0]           to4k;
  logic [CW-1:0]        blen_calc;

  logic                 take_pend;
  logic                 take_flag;
  logic                 flag_to_pend;
  logic                 flag_drop;
  logic                 start_now;
  logic [LITEWIDTH-1:0] start_addr;
  logic [LENWIDTH-1:0]  start_len;

  logic                 unused_bits;

  assign axi.arsize  = 3'b100;
  assign axi.arburst = 2'b01;
  assign axi.rready  = I_data_ready;

  assign ar_hs      = axi.arvalid & axi.arready;
  assign beat       = axi.rvalid & axi.rready;
  assign drain_done = (state == DRAIN) && (expect_q == '0);

  // Distance to the next 4 KB boundary: 256 beats of 16 bytes per 4 KB page.
  assign to4k = 9'd256 - {1'b0, addr_q[7:0]};

  // Burst length: smallest of remaining beats, MAX_BURST and the 4 KB distance.
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition so no path can infer a latch.
    blen_calc = remain_q;
    if (blen_calc > CW'(MAX_BURST)) blen_calc = CW'(MAX_BURST);
    if (blen_calc > CW'(to4k))      blen_calc = CW'(to4k);
  end

  // Request routing: start a line now, park it in the pending slot, or drop it.
  // A flag arriving while the pending slot is being consumed still sees the
  // slot as full and is dropped; a flag at line completion with an empty slot
  // starts immediately.
  always_comb begin
    take_pend    = drain_done & pend_valid;
    take_flag    = I_rd_flag & ((state == IDLE) | (drain_done & ~pend_valid));
    flag_to_pend = I_rd_flag & ~take_flag & ~pend_valid;
    flag_drop    = I_rd_flag & ~take_flag & pend_valid;
    start_now    = take_pend | take_flag;
    start_addr   = take_pend ? pend_addr : I_rd_addr;
    start_len    = take_pend ? pend_len  : I_beat_num;
  end

  // Control FSM, burst issue, beat accounting and the pending slot.
  always_ff @(posedge I_clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (I_rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      blen_q      <= '0;
      expect_q    <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_len    <= '0;
      O_busy      <= 1'b0;
      O_line_done <= 1'b0;
      O_overflow  <= 1'b0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arvalid <= 1'b0;
    end else begin
      O_line_done <= 1'b0;

      if (flag_drop) O_overflow <= 1'b1;

      if (take_pend) pend_valid <= 1'b0;
      if (flag_to_pend) begin
        pend_valid <= 1'b1;
        pend_addr  <= I_rd_addr;
        pend_len   <= I_beat_num;
      end

      // Issue and return may coincide; a beat never takes the count below 0.
      expect_q <= expect_q + (ar_hs ? blen_q : '0)
                           - ((beat && expect_q != '0) ? CW'(1) : '0);

      case (state)
        IDLE: begin
          if (start_now) O_busy <= 1'b1;
        end
        CALC: begin
          O_busy      <= 1'b1;
          axi.araddr  <= {addr_q[LITEWIDTH-5:0], 4'b0000};
          axi.arlen   <= 8'(blen_calc - CW'(1));
          blen_q      <= blen_calc;
          axi.arvalid <= 1'b1;
          state       <= AREQ;
        end
        AREQ: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            addr_q      <= addr_q + LITEWIDTH'(blen_q);
            remain_q    <= remain_q - blen_q;
            state       <= (remain_q == blen_q) ? DRAIN : CALC;
          end
        end
        DRAIN: begin
          if (expect_q == '0) begin
            O_line_done <= 1'b1;
            O_busy      <= 1'b0;
            state       <= IDLE;
          end else begin
            O_busy      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A newly started line overrides the next state chosen above.
      if (start_now) begin
        addr_q   <= start_addr;
        remain_q <= {1'b0, start_len};
        state    <= (start_len == '0) ? DRAIN : CALC;
      end
    end
  end

  // Forwarding register: each accepted R beat appears one cycle later.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_data       <= '0;
      O_data_valid <= 1'b0;
    end else begin
      O_data_valid <= beat;
      if (beat) O_data <= axi.rdata;
    end
  end

`ifdef DRAM_RD_RRESP_CHECK_EN
  // Sticky flag for any accepted beat carrying a non-OKAY response.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_rresp_err <= 1'b0;
    end else if (beat && axi.rresp != 2'b00) begin
      O_rresp_err <= 1'b1;
    end
  end

  assign unused_bits = ^{axi.rlast, addr_q[LITEWIDTH-1 -: 4]};
`else
  assign O_rresp_err = 1'b0;

  assign unused_bits = ^{axi.rlast, axi.rresp, addr_q[LITEWIDTH-1 -: 4]};
`endif

endmodule

// File: tb/tb_dram_feature_rd_burst.sv
// Self-checking bench for dram_feature_rd_burst: a line-level model predicts
// the burst list of every accepted line, the beat count per line, the sticky
// flags and the forwarded data; directed tests pin the model with literals.
module tb_dram_feature_rd_burst;

  typedef struct {
    logic [31:0] araddr;
    logic [7:0]  arlen;
  } ar_t;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } rbeat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_flag = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic [18:0]  beat_num = '0;
  logic         data_ready = 1'b1;
  logic         busy, line_done, overflow, data_valid, rresp_err;
  logic [127:0] data;

  dram_feature_rd_burst_if #(.LITEWIDTH(32), .AXIWIDTH(128)) axi ();

  dram_feature_rd_burst dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_rd_flag    (rd_flag),
    .I_rd_addr    (rd_addr),
    .I_beat_num   (beat_num),
    .O_busy       (busy),
    .O_line_done  (line_done),
    .O_overflow   (overflow),
    .axi          (axi),
    .I_data_ready (data_ready),
    .O_data       (data),
    .O_data_valid (data_valid),
    .O_rresp_err  (rresp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  ar_t          exp_ar[$];
  ar_t          seen_ar[$];
  rbeat_t       r_q[$];
  int           line_len_q[$];
  bit           m_ovf = 0;
  bit           m_rerr = 0;
  bit           prev_hs = 0;
  logic [127:0] prev_data = '0;
  bit           prev_ar_wait = 0;
  ar_t          prev_ar;
  int           beats_since = 0;
  int           done_count = 0;
  int           dv_count = 0;

  // Slave-side knobs
  int ar_pct = 100;
  int rv_pct = 100;
  int dr_mode = 0;
  bit ar_hold = 0;
  bit rv_busy = 0;
  bit inject_resp = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Split a line into bursts from the rules: min(remaining, 16, beats to 4 KB).
  function automatic void add_line(input logic [31:0] a, input int len);
    int          rem;
    int          to4k;
    int          b;
    logic [31:0] cur;
    ar_t         e;
    rem = len;
    cur = a;
    while (rem > 0) begin
      to4k = 256 - int'(cur[7:0]);
      b = rem;
      if (b > 16)   b = 16;
      if (b > to4k) b = to4k;
      e.araddr = cur << 4;
      e.arlen  = 8'(b - 1);
      exp_ar.push_back(e);
      cur = cur + 32'(b);
      rem = rem - b;
    end
  endfunction

  // Slave drivers: change inputs just after the active edge.
  always @(posedge clk) begin
    #1;
    axi.arready = ar_hold ? 1'b0 : ($urandom_range(99) < ar_pct);
    case (dr_mode)
      0:       data_ready = 1'b1;
      1:       data_ready = ~data_ready;
      default: data_ready = 1'($urandom_range(1));
    endcase
    if (!rv_busy) begin
      if (r_q.size() > 0 && $urandom_range(99) < rv_pct) begin
        axi.rvalid = 1'b1;
        axi.rdata  = r_q[0].data;
        axi.rlast  = r_q[0].last;
        axi.rresp  = inject_resp ? 2'b10 : 2'b00;
        inject_resp = 0;
        rv_busy = 1;
      end else begin
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
      end
    end
  end

  // Compare process: sample everything mid-cycle, check, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_ar.delete();
      r_q.delete();
      line_len_q.delete();
      m_ovf = 0;
      m_rerr = 0;
      prev_hs = 0;
      prev_ar_wait = 0;
      beats_since = 0;
      rv_busy = 0;
    end else begin
      check("rready", axi.rready, data_ready);
      check("arsize", axi.arsize, 3'b100);
      check("arburst", axi.arburst, 2'b01);
      check("data_valid", data_valid, prev_hs);
      if (prev_hs) check("data", data, prev_data);
      if (data_valid) dv_count++;
      check("overflow", overflow, m_ovf);
      check("rresp_err", rresp_err, m_rerr);
      if (prev_ar_wait) begin
        check("ar_hold_valid", axi.arvalid, 1'b1);
        check("ar_hold_addr", axi.araddr, prev_ar.araddr);
        check("ar_hold_len", axi.arlen, prev_ar.arlen);
      end

      if (line_done) begin
        check("done_expected", line_len_q.size() != 0, 1'b1);
        if (line_len_q.size() != 0) begin
          check("done_beats", beats_since, line_len_q[0]);
          void'(line_len_q.pop_front());
        end
        beats_since = 0;
        done_count++;
      end

      if (axi.arvalid && axi.arready) begin
        ar_t got;
        got.araddr = axi.araddr;
        got.arlen  = axi.arlen;
        seen_ar.push_back(got);
        check("ar_expected", exp_ar.size() != 0, 1'b1);
        if (exp_ar.size() != 0) begin
          check("araddr", got.araddr, exp_ar[0].araddr);
          check("arlen", got.arlen, exp_ar[0].arlen);
          void'(exp_ar.pop_front());
        end
        for (int k = 0; k <= int'(got.arlen); k++) begin
          rbeat_t rb;
          rb.data = {$urandom, $urandom, $urandom, $urandom};
          rb.last = (k == int'(got.arlen));
          r_q.push_back(rb);
        end
      end

      if (axi.rvalid && axi.rready) begin
        prev_hs = 1;
        prev_data = axi.rdata;
        beats_since++;
`ifdef DRAM_RD_RRESP_CHECK_EN
        if (axi.rresp != 2'b00) m_rerr = 1;
`endif
        if (r_q.size() != 0) void'(r_q.pop_front());
        rv_busy = 0;
      end else begin
        prev_hs = 0;
      end

      prev_ar_wait = axi.arvalid && !axi.arready;
      prev_ar.araddr = axi.araddr;
      prev_ar.arlen  = axi.arlen;

      if (rd_flag) begin
        if (line_len_q.size() < 2) begin
          line_len_q.push_back(int'(beat_num));
          add_line(rd_addr, int'(beat_num));
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  task automatic send_line(input logic [31:0] a, input int len);
    @(posedge clk); #1;
    rd_flag  = 1'b1;
    rd_addr  = a;
    beat_num = 19'(len);
    @(posedge clk); #1;
    rd_flag  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((line_len_q.size() != 0 || r_q.size() != 0 || exp_ar.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("idle_timeout", n < budget, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_ar(input string name, input int idx, input logic [31:0] a, input logic [7:0] l);
    check({name, "_present"}, idx < seen_ar.size(), 1'b1);
    if (idx < seen_ar.size()) begin
      check({name, "_addr"}, seen_ar[idx].araddr, a);
      check({name, "_len"}, seen_ar[idx].arlen, l);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ar0, dv0, dn0;
    logic [31:0] ra;

    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", line_done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_araddr", axi.araddr, 32'h0);
    check("rst_arlen", axi.arlen, 8'h0);
    check("rst_arsize", axi.arsize, 3'b100);
    check("rst_arburst", axi.arburst, 2'b01);
    check("rst_dv", data_valid, 1'b0);
    check("rst_data", data, 128'h0);
    check("rst_rerr", rresp_err, 1'b0);
    rst = 1'b0;

    // Basic line: 0x100, 40 beats
    ar0 = seen_ar.size(); dv0 = dv_count; dn0 = done_count;
    send_line(32'h100, 40);
    check("basic_busy", busy, 1'b1);
    check("basic_arvalid_early", axi.arvalid, 1'b0);
    @(posedge clk); #1;
    check("basic_arvalid_t2", axi.arvalid, 1'b1);
    check("basic_araddr_t2", axi.araddr, 32'h1000);
    wait_idle(2000);
    check("basic_nbursts", seen_ar.size() - ar0, 3);
    check_ar("basic_b0", ar0,     32'h1000, 8'd15);
    check_ar("basic_b1", ar0 + 1, 32'h1100, 8'd15);
    check_ar("basic_b2", ar0 + 2, 32'h1200, 8'd7);
    check("basic_beats", dv_count - dv0, 40);
    check("basic_dones", done_count - dn0, 1);
    check("basic_busy_end", busy, 1'b0);

    // 4 KB split
    ar0 = seen_ar.size();
    send_line(32'hF8, 20);
    wait_idle(2000);
    check("split_nbursts", seen_ar.size() - ar0, 2);
    check_ar("split_b0", ar0,     32'hF80, 8'd7);
    check_ar("split_b1", ar0 + 1, 32'h1000, 8'd11);

    // Zero length
    ar0 = seen_ar.size(); dn0 = done_count;
    send_line(32'h40, 0);
    check("zero_busy", busy, 1'b1);
    check("zero_done_early", line_done, 1'b0);
    @(posedge clk); #1;
    check("zero_done", line_done, 1'b1);
    check("zero_busy_end", busy, 1'b0);
    @(posedge clk); #1;
    check("zero_done_pulse", line_done, 1'b0);
    check("zero_no_ar", seen_ar.size() - ar0, 0);
    check("zero_dones", done_count - dn0, 1);

    // Backpressure: AR stalled 5 cycles, data_ready toggling
    ar0 = seen_ar.size(); dv0 = dv_count; dn0 = done_count;
    ar_hold = 1; dr_mode = 1;
    send_line(32'h2F0, 33);
    repeat (5) @(posedge clk);
    #1;
    check("bp_arvalid", axi.arvalid, 1'b1);
    check("bp_araddr", axi.araddr, 32'h2F00);
    check("bp_arlen", axi.arlen, 8'd15);
    ar_hold = 0;
    wait_idle(2000);
    check("bp_beats", dv_count - dv0, 33);
    check("bp_dones", done_count - dn0, 1);
    check_ar("bp_b2", ar0 + 2, 32'h3100, 8'd0);
    dr_mode = 0;

    // Queueing: second request pends, third overflows
    ar0 = seen_ar.size(); dv0 = dv_count; dn0 = done_count;
    send_line(32'h0, 20);
    send_line(32'h10, 5);
    send_line(32'h20, 7);
    repeat (2) @(posedge clk);
    #1;
    check("q_overflow", overflow, 1'b1);
    wait_idle(3000);
    check("q_nbursts", seen_ar.size() - ar0, 3);
    check_ar("q_l2", ar0 + 2, 32'h100, 8'd4);
    check("q_dones", done_count - dn0, 2);
    check("q_beats", dv_count - dv0, 25);

    // Reset while a burst waits on the AR channel
    ar_hold = 1;
    send_line(32'h500, 10);
    @(posedge clk); #1;
    check("rst_mid_arvalid_before", axi.arvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_arvalid", axi.arvalid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ovf", overflow, 1'b0);
    ar_hold = 0;
    ar0 = seen_ar.size();
    send_line(32'h7FF, 3);
    wait_idle(2000);
    check_ar("rec_b0", ar0,     32'h7FF0, 8'd0);
    check_ar("rec_b1", ar0 + 1, 32'h8000, 8'd1);

    // Response error on one beat
    inject_resp = 1;
    send_line(32'h900, 4);
    wait_idle(2000);
`ifdef DRAM_RD_RRESP_CHECK_EN
    check("rresp_err_set", rresp_err, 1'b1);
`else
    check("rresp_err_tied", rresp_err, 1'b0);
`endif

    // Randomized traffic
    ar_pct = 60; rv_pct = 70; dr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(2) == 0) ra[7:0] = 8'(256 - $urandom_range(1, 20));
      send_line(ra, $urandom_range(0, 70));
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    wait_idle(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
